// File: rtl/amp_ctrl_pkg.sv
// Shared constants and types for the amplitude limit controller.
package amp_ctrl_pkg;

   localparam int unsigned AMP_W  = 16;
   localparam int unsigned AMP_XW = AMP_W + 1;
   localparam int unsigned ST_W   = 2;
   localparam int unsigned GAIN_W = 2;

   localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [ST_W-1:0] ST_MEASURE = 2'd1;
   localparam logic [ST_W-1:0] ST_DECIDE  = 2'd2;
   localparam logic [ST_W-1:0] ST_APPLY   = 2'd3;

   localparam logic [GAIN_W-1:0] GAIN_STEADY  = 2'd0;
   localparam logic [GAIN_W-1:0] GAIN_ATTACK  = 2'd1;
   localparam logic [GAIN_W-1:0] GAIN_RELEASE = 2'd2;

   localparam int unsigned DEF_WIN_LEN    = 64;
   localparam int unsigned DEF_HIGH_LEVEL = 30000;
   localparam int unsigned DEF_LOW_LEVEL  = 12000;
   localparam int unsigned DEF_MAX_THRESH = 32767;
   localparam int unsigned DEF_MIN_THRESH = 4096;
   localparam int unsigned DEF_ATK_SHIFT  = 3;
   localparam int unsigned DEF_RLS_STEP   = 256;
   localparam int unsigned DEF_HOLD_WIN   = 4;

   // Pending threshold decision carried from DECIDE into APPLY.
   typedef struct packed {
      logic [GAIN_W-1:0] gain;
      logic [AMP_W-1:0]  thresh;
   } decision_t;

   function automatic logic [AMP_W-1:0] amp_max(input logic [AMP_W-1:0] a,
                                                input logic [AMP_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/amp_peak_win.sv
// Valid-qualified windowed peak detector; strobes o_win_end_c on the window-closing sample.
module amp_peak_win
   import amp_ctrl_pkg::*;
#(
   parameter int unsigned WIN_LEN = DEF_WIN_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic             i_valid,
   input  logic [AMP_W-1:0] i_amp,
   output logic [AMP_W-1:0] o_peak,
   output logic             o_win_end_c
);

   localparam int unsigned CNT_W = $clog2(WIN_LEN);

   logic [CNT_W-1:0] r_cnt;
   logic [AMP_W-1:0] r_run_peak;
   logic [AMP_W-1:0] w_peak;

   assign w_peak      = amp_max(r_run_peak, i_amp);
   assign o_win_end_c = i_run & i_valid & (r_cnt == CNT_W'(WIN_LEN - 1));

   // Window close publishes the peak and restarts the count in the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_run_peak <= '0;
         o_peak     <= '0;
      end else if (!i_run) begin
         r_cnt      <= '0;
         r_run_peak <= '0;
      end else if (i_valid) begin
         if (o_win_end_c) begin
            o_peak     <= w_peak;
            r_cnt      <= '0;
            r_run_peak <= '0;
         end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_run_peak <= w_peak;
         end
      end
   end

endmodule

// File: rtl/amp_limit_ctrl.sv
// Attack/release threshold scheduler driving the amp_limiter threshold from windowed peaks.
module amp_limit_ctrl
   import amp_ctrl_pkg::*;
#(
   parameter int unsigned WIN_LEN    = DEF_WIN_LEN,
   parameter int unsigned HIGH_LEVEL = DEF_HIGH_LEVEL,
   parameter int unsigned LOW_LEVEL  = DEF_LOW_LEVEL,
   parameter int unsigned MAX_THRESH = DEF_MAX_THRESH,
   parameter int unsigned MIN_THRESH = DEF_MIN_THRESH,
   parameter int unsigned ATK_SHIFT  = DEF_ATK_SHIFT,
   parameter int unsigned RLS_STEP   = DEF_RLS_STEP,
   parameter int unsigned HOLD_WIN   = DEF_HOLD_WIN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              valid,
   input  logic [AMP_W-1:0]  amplitude,
   output logic [AMP_W-1:0]  limit_thresh,
   output logic              thresh_update,
   output logic [AMP_W-1:0]  peak_out,
   output logic [GAIN_W-1:0] gain_state
);

   localparam int unsigned HOLD_W = $clog2(HOLD_WIN + 1);

   localparam logic [AMP_W-1:0]  C_HIGH  = AMP_W'(HIGH_LEVEL);
   localparam logic [AMP_W-1:0]  C_LOW   = AMP_W'(LOW_LEVEL);
   localparam logic [AMP_W-1:0]  C_MAX   = AMP_W'(MAX_THRESH);
   localparam logic [AMP_W-1:0]  C_MIN   = AMP_W'(MIN_THRESH);
   localparam logic [AMP_XW-1:0] C_MAX_X = AMP_XW'(MAX_THRESH);

   logic [ST_W-1:0]   r_state;
   logic [ST_W-1:0]   w_state_nxt;
   decision_t         r_dec;
   decision_t         w_dec_nxt;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [AMP_W-1:0]  w_thresh_nxt;
   logic              w_upd_nxt;
   logic [GAIN_W-1:0] w_gain_nxt;
   logic [AMP_W-1:0]  w_atk;
   logic [AMP_XW-1:0] w_rls;
   logic              w_run;
   logic              w_win_end;

   assign w_run = enable & (r_state != ST_IDLE);
   assign w_atk = limit_thresh - (limit_thresh >> ATK_SHIFT);
   assign w_rls = {1'b0, limit_thresh} + AMP_XW'(RLS_STEP);

   amp_peak_win #(
      .WIN_LEN     (WIN_LEN)
   ) u_peak_win (
      .clk         (clk),
      .rst         (rst),
      .i_run       (w_run),
      .i_valid     (valid),
      .i_amp       (amplitude),
      .o_peak      (peak_out),
      .o_win_end_c (w_win_end)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_dec         <= '0;
         r_hold        <= '0;
         limit_thresh  <= C_MAX;
         thresh_update <= 1'b0;
         gain_state    <= GAIN_STEADY;
      end else begin
         r_state       <= w_state_nxt;
         r_dec         <= w_dec_nxt;
         r_hold        <= w_hold_nxt;
         limit_thresh  <= w_thresh_nxt;
         thresh_update <= w_upd_nxt;
         gain_state    <= w_gain_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_dec_nxt    = r_dec;
      w_hold_nxt   = r_hold;
      w_thresh_nxt = limit_thresh;
      w_upd_nxt    = 1'b0;
      w_gain_nxt   = gain_state;
      case (r_state)
         ST_IDLE: begin
            w_hold_nxt = '0;
            if (enable) w_state_nxt = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
               w_hold_nxt  = '0;
            end else if (w_win_end) begin
               w_state_nxt = ST_DECIDE;
            end
         end
         ST_DECIDE: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
               w_hold_nxt  = '0;
            end else begin
               w_state_nxt = ST_APPLY;
               w_dec_nxt   = '{gain: GAIN_STEADY, thresh: limit_thresh};
               w_hold_nxt  = '0;
               if (peak_out > C_HIGH) begin
                  w_dec_nxt.gain   = GAIN_ATTACK;
                  w_dec_nxt.thresh = (w_atk < C_MIN) ? C_MIN : w_atk;
               end else if (peak_out < C_LOW) begin
                  // Quiet windows accumulate; only the HOLD_WIN-th one releases.
                  if (r_hold == HOLD_W'(HOLD_WIN - 1)) begin
                     w_dec_nxt.gain   = GAIN_RELEASE;
                     w_dec_nxt.thresh = (w_rls > C_MAX_X) ? C_MAX : w_rls[AMP_W-1:0];
                  end else begin
                     w_hold_nxt = r_hold + HOLD_W'(1);
                  end
               end
            end
         end
         ST_APPLY: begin
            w_thresh_nxt = r_dec.thresh;
            w_upd_nxt    = (r_dec.thresh != limit_thresh);
            w_gain_nxt   = r_dec.gain;
            if (enable) begin
               w_state_nxt = ST_MEASURE;
            end else begin
               w_state_nxt = ST_IDLE;
               w_hold_nxt  = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: doc/amp_limit_ctrl.md
Name: amp_limit_ctrl

Overview:
Threshold scheduler for the amp_limiter datapath. It watches the same valid-qualified unsigned amplitude stream that feeds the limiter and measures the peak over fixed windows of valid samples. An attack/release state machine then lowers or raises the limit threshold and drives the limiter's threshold input, with a one-cycle update strobe. Sits beside amp_limiter in the receive amplitude path, one clock domain.

Parameters:
WIN_LEN, 64, valid samples per measurement window (power of 2, >=4)
HIGH_LEVEL, 30000, window peak strictly above this triggers attack
LOW_LEVEL, 12000, window peak strictly below this counts as a quiet window
MAX_THRESH, 32767, threshold ceiling and reset value
MIN_THRESH, 4096, threshold floor
ATK_SHIFT, 3, attack step = thresh >> ATK_SHIFT
RLS_STEP, 256, release increment
HOLD_WIN, 4, consecutive quiet windows required before each release

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  run control; 0 freezes the threshold
valid  in  1  one-cycle sample strobe, same as the limiter's valid
amplitude  in  16  unsigned sample magnitude
limit_thresh  out  16  threshold to amp_limiter
thresh_update  out  1  one-cycle pulse when limit_thresh changes
peak_out  out  16  peak of the last completed window
gain_state  out  2  0=steady, 1=attack, 2=release (last decision)

Behaviour:
- Reset (async, rst=1): limit_thresh=MAX_THRESH, thresh_update=0, peak_out=0, gain_state=0, FSM=IDLE. Running peak, window count and hold count are all 0.
- Measurement runs every cycle in MEASURE/DECIDE/APPLY:
  - On valid=1, run_peak=max(run_peak, amplitude) and win_cnt increments.
  - On the valid that makes win_cnt=WIN_LEN-1→wrap, the window ends: peak_out<=max(run_peak, amplitude), then run_peak and win_cnt clear in the same edge.
  - A valid on the very next cycle belongs to the new window. No samples are dropped.
- FSM states:
  - IDLE: nothing counted. If enable=1, go to MEASURE with counters cleared.
  - MEASURE: on window end, go to DECIDE.
  - DECIDE (1 cycle): classify peak_out.
    - peak_out>HIGH_LEVEL → attack: cand=thresh-(thresh>>ATK_SHIFT), clamped to >=MIN_THRESH. hold_cnt=0.
    - peak_out<LOW_LEVEL → hold_cnt+1. If that reaches HOLD_WIN → release: cand=thresh+RLS_STEP in 17-bit arithmetic, clamped to <=MAX_THRESH, and hold_cnt=0.
    - Otherwise → steady: hold_cnt=0, no change.
  - APPLY (1 cycle): if cand!=limit_thresh, register it and pulse thresh_update for exactly this cycle. gain_state is updated to the decision (attack/release/steady). Return to MEASURE.
- Latency: thresh_update is asserted 2 clocks after the window-closing valid edge.
- Clamped no-op: a clamped result equal to the current threshold gives no pulse, but gain_state is still updated.
- WIN_LEN >=4 and valid spacing >=1 cycle guarantee DECIDE/APPLY finish before the next window end.
- enable=0 in any state: go to IDLE next cycle and clear run_peak, win_cnt and hold_cnt. limit_thresh and peak_out hold. An APPLY cycle in progress completes first.
- rst asserted mid-window: immediate return to reset values.
- amplitude is compared as unsigned. 53000 counts as above HIGH_LEVEL.

Decomposition:
- Package amp_ctrl_pkg: FSM state encoding (IDLE, MEASURE, DECIDE, APPLY), gain_state codes, default level constants.
- Sub-module amp_peak_win: valid-qualified windowed peak detector with window-end strobe. It is reusable by other amplitude monitors.
- Decision logic and FSM stay in amp_limit_ctrl.

Test Plan:
1. Reset, enable=1, 64 valids with amplitude=480 (valid every 5 clocks) → peak_out=480, quiet window, hold_cnt=1, no pulse, limit_thresh=32767.
2. One window ramping 0..40000, then defaults → peak_out=40000, pulse 2 clocks after the last valid, limit_thresh 32767→28672, gain_state=1. Second such window → 25088.
3. Repeat attack windows until the floor → value steps down and sticks at 4096. The clamped window that keeps 4096 produces no pulse, gain_state=1.
4. From 4096, 8 windows of peak 1000 → pulses after windows 4 and 8 only, thresh 4352 then 4608, gain_state=2. Also: from 32600, a release clamps to 32767.
5. Quiet ×3, then peak 20000, then quiet ×3 → hold_cnt resets, no release pulse, gain_state=0.
6. Drop enable halfway through a window of 40000, then re-enable → no pulse, thresh held. The next full window starts from count 0 and attacks normally. Assert rst mid-window → thresh=32767 immediately.
